// File: rtl/ppu_vram_arb_if.sv
// Purpose : bundles the requester-side and VRAM-side signals of the PPU VRAM arbiter.
// Latency : none; this is wiring only.
// Backpr. : none; requesters hold req until their one-cycle grant strobe.
// Ports   : render_in, bg/spr/cpu request lines with addresses and CPU write data,
//           bg/spr/cpu grant and rvalid strobes, shared rd_d_out, and the VRAM port
//           (vram_a_out, vram_we_out, vram_d_out, vram_d_in).
//           Modport slave is the arbiter; modport master is the requesters plus VRAM.
interface ppu_vram_arb_if #(
  parameter int ADDR_W = 14
);
  // Requester side
  logic              render_in;
  logic              bg_req_in;
  logic [ADDR_W-1:0] bg_a_in;
  logic              spr_req_in;
  logic [ADDR_W-1:0] spr_a_in;
  logic              cpu_req_in;
  logic              cpu_we_in;
  logic [ADDR_W-1:0] cpu_a_in;
  logic [7:0]        cpu_d_in;
  logic              bg_gnt_out;
  logic              spr_gnt_out;
  logic              cpu_gnt_out;
  logic              bg_rvalid_out;
  logic              spr_rvalid_out;
  logic              cpu_rvalid_out;
  logic [7:0]        rd_d_out;

  // Synchronous VRAM side
  logic [ADDR_W-1:0] vram_a_out;
  logic              vram_we_out;
  logic [7:0]        vram_d_out;
  logic [7:0]        vram_d_in;

  modport slave (
    input  render_in,
    input  bg_req_in, bg_a_in,
    input  spr_req_in, spr_a_in,
    input  cpu_req_in, cpu_we_in, cpu_a_in, cpu_d_in,
    output bg_gnt_out, spr_gnt_out, cpu_gnt_out,
    output bg_rvalid_out, spr_rvalid_out, cpu_rvalid_out,
    output rd_d_out,
    output vram_a_out, vram_we_out, vram_d_out,
    input  vram_d_in
  );

  modport master (
    output render_in,
    output bg_req_in, bg_a_in,
    output spr_req_in, spr_a_in,
    output cpu_req_in, cpu_we_in, cpu_a_in, cpu_d_in,
    input  bg_gnt_out, spr_gnt_out, cpu_gnt_out,
    input  bg_rvalid_out, spr_rvalid_out, cpu_rvalid_out,
    input  rd_d_out,
    input  vram_a_out, vram_we_out, vram_d_out,
    output vram_d_in
  );
endinterface

// File: rtl/ppu_vram_arb.sv
// Purpose : arbitrates BG fetch, sprite fetch and CPU register port onto one synchronous VRAM.
// Latency : req sampled in IDLE -> grant strobe next cycle -> rvalid + rd_d_out 3 cycles after req.
// Backpr. : no queueing; a losing requester keeps req high and is re-sampled at the next IDLE.
// Ports   : clk_in (rising edge), rst_n_in (async, active low), bus (ppu_vram_arb_if.slave):
//           request/address/write-data inputs, grant and rvalid strobes, rd_d_out, VRAM port.
// Option  : define PPU_VRAM_ARB_STARVE_EN to add a CPU anti-starvation counter; after
//           STARVE_LIMIT consecutive lost arbitrations the CPU wins regardless of render_in.
module ppu_vram_arb #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 15
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  ppu_vram_arb_if.slave bus
);

  // One-hot requester encoding used for winner, grant and rvalid vectors.
  localparam int B_BG  = 2;
  localparam int B_SPR = 1;
  localparam int B_CPU = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        win_d;        // arbitration winner, non-zero only in IDLE
  logic [ADDR_W-1:0] win_a;
  logic              win_we;
  logic              any_req;
  logic              cpu_force;    // starvation override

  logic [2:0]        owner_q;      // requester that owns the access in flight
  logic              rd_op_q;      // access in flight is a read
  logic [2:0]        gnt_q;
  logic [2:0]        rvalid_q;
  logic [ADDR_W-1:0] vram_a_q;
  logic              vram_we_q;
  logic [7:0]        vram_d_q;
  logic [7:0]        rd_d_q;

  assign any_req = bus.bg_req_in | bus.spr_req_in | bus.cpu_req_in;

  // --------------------------------------------------------------------------
  // CPU starvation counter
  // --------------------------------------------------------------------------
`ifdef PPU_VRAM_ARB_STARVE_EN
  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign cpu_force = bus.cpu_req_in && (starve_q == CNT_W'(STARVE_LIMIT));

  // Only IDLE cycles are arbitration points. A lost arbitration while the CPU
  // is asking bumps the count; a CPU win or a dropped CPU request clears it.
  // The override fires at the limit, so the count never passes STARVE_LIMIT.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE) begin
      if (!bus.cpu_req_in || win_d[B_CPU]) begin
        starve_d = '0;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign cpu_force = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: next state and arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    win_d   = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ISSUE;
          if (cpu_force) begin
            win_d[B_CPU] = 1'b1;
          end else if (bus.render_in) begin
            // Rendering: pixel fetches must not miss their slot.
            if (bus.bg_req_in)       win_d[B_BG]  = 1'b1;
            else if (bus.spr_req_in) win_d[B_SPR] = 1'b1;
            else                     win_d[B_CPU] = 1'b1;
          end else begin
            // Blanking: the CPU owns VRAM first.
            if (bus.cpu_req_in)      win_d[B_CPU] = 1'b1;
            else if (bus.bg_req_in)  win_d[B_BG]  = 1'b1;
            else                     win_d[B_SPR] = 1'b1;
          end
        end
      end
      ST_ISSUE: state_d = ST_DATA;
      ST_DATA:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner's address/write-enable, selected from the one-hot winner.
  always_comb begin
    win_a = bus.cpu_a_in;
    if (win_d[B_BG]) begin
      win_a = bus.bg_a_in;
    end else if (win_d[B_SPR]) begin
      win_a = bus.spr_a_in;
    end
  end

  assign win_we = win_d[B_CPU] & bus.cpu_we_in;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // The VRAM port registers double as the request latch: loaded at the IDLE
  // edge, so they present the access during ISSUE. The address and write data
  // are left holding afterwards; only the write strobe is forced low again.
  // The VRAM returns data during DATA, captured at the DATA edge so rvalid and
  // rd_d_out appear together in the following IDLE cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      owner_q   <= 3'b000;
      rd_op_q   <= 1'b0;
      gnt_q     <= 3'b000;
      rvalid_q  <= 3'b000;
      vram_a_q  <= '0;
      vram_we_q <= 1'b0;
      vram_d_q  <= '0;
      rd_d_q    <= '0;
    end else begin
      gnt_q     <= 3'b000;
      rvalid_q  <= 3'b000;
      vram_we_q <= 1'b0;

      if (state_q == ST_IDLE && win_d != 3'b000) begin
        owner_q   <= win_d;
        rd_op_q   <= ~win_we;
        gnt_q     <= win_d;
        vram_a_q  <= win_a;
        vram_we_q <= win_we;
        if (win_we) begin
          vram_d_q <= bus.cpu_d_in;
        end
      end

      // A CPU write completes with its grant; only reads get an rvalid.
      if (state_q == ST_DATA && rd_op_q) begin
        rd_d_q   <= bus.vram_d_in;
        rvalid_q <= owner_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.bg_gnt_out     = gnt_q[B_BG];
  assign bus.spr_gnt_out    = gnt_q[B_SPR];
  assign bus.cpu_gnt_out    = gnt_q[B_CPU];
  assign bus.bg_rvalid_out  = rvalid_q[B_BG];
  assign bus.spr_rvalid_out = rvalid_q[B_SPR];
  assign bus.cpu_rvalid_out = rvalid_q[B_CPU];
  assign bus.rd_d_out       = rd_d_q;
  assign bus.vram_a_out     = vram_a_q;
  assign bus.vram_we_out    = vram_we_q;
  assign bus.vram_d_out     = vram_d_q;

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Purpose : self-checking bench for ppu_vram_arb with a behavioural VRAM and reference model.
// Latency : checks grant at req+1 and rvalid/read data at req+3.
// Backpr. : requesters hold req until granted, then drop or re-request.
module tb_ppu_vram_arb;

  localparam int ADDR_W       = 14;
  localparam int STARVE_LIMIT = 15;
  localparam int N_RAND       = 1500;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  ppu_vram_arb_if #(.ADDR_W(ADDR_W)) bus ();

  ppu_vram_arb #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Initial VRAM contents; chosen so that location 0x2001 holds 0x5A.
  function automatic logic [7:0] vram_init(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[13:6] ^ 8'hDB;
  endfunction

  // Behavioural synchronous VRAM: read data one cycle after the address.
  logic [7:0] vram_mem [int];
  always @(posedge clk) begin
    bus.vram_d_in <= vram_mem.exists(int'(bus.vram_a_out)) ?
                     vram_mem[int'(bus.vram_a_out)] : vram_init(bus.vram_a_out);
    if (bus.vram_we_out) vram_mem[int'(bus.vram_a_out)] = bus.vram_d_out;
  end

  // Reference view of memory contents, updated from the bench's own knowledge of writes.
  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_read(input logic [ADDR_W-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return vram_init(a);
  endfunction

  // Expected events of the random phase, keyed by cycle number.
  bit   [2:0]        m_gnt [int];
  bit   [2:0]        m_rv  [int];
  logic [7:0]        m_rd  [int];
  logic [ADDR_W-1:0] m_a   [int];
  bit                m_we  [int];
  logic [7:0]        m_wd  [int];

  function automatic logic [2:0] gnt_vec();
    return {bus.bg_gnt_out, bus.spr_gnt_out, bus.cpu_gnt_out};
  endfunction

  function automatic logic [2:0] rv_vec();
    return {bus.bg_rvalid_out, bus.spr_rvalid_out, bus.cpu_rvalid_out};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.bg_req_in  = 1'b0;
    bus.spr_req_in = 1'b0;
    bus.cpu_req_in = 1'b0;
    bus.cpu_we_in  = 1'b0;
  endtask

  task automatic go_idle();
    clear_reqs();
    repeat (4) step();
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] a;
    a = 14'h0123;
    rst_n = 1'b0;
    clear_reqs();
    bus.render_in = 1'b1;
    bus.bg_a_in   = '0;
    bus.spr_a_in  = '0;
    bus.cpu_a_in  = '0;
    bus.cpu_d_in  = '0;
    repeat (3) step();
    checks++; if (gnt_vec() !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b want=000", gnt_vec()); end
    checks++; if (rv_vec() !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b want=000", rv_vec()); end
    checks++; if (bus.vram_we_out !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", bus.vram_we_out); end
    checks++; if (bus.vram_a_out !== '0) begin failures++; $display("FAIL reset_addr got=%h want=0", bus.vram_a_out); end
    checks++; if (bus.vram_d_out !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h want=00", bus.vram_d_out); end
    checks++; if (bus.rd_d_out !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h want=00", bus.rd_d_out); end
    // Release and request together: the first IDLE after release must arbitrate.
    rst_n = 1'b1;
    bus.bg_req_in = 1'b1;
    bus.bg_a_in   = a;
    step();
    checks++; if (gnt_vec() !== 3'b100) begin failures++; $display("FAIL first_arb_gnt got=%b want=100", gnt_vec()); end
    checks++; if (bus.vram_a_out !== a) begin failures++; $display("FAIL first_arb_addr got=%h want=%h", bus.vram_a_out, a); end
    clear_reqs();
    step();
    step();
    checks++; if (rv_vec() !== 3'b100) begin failures++; $display("FAIL first_arb_rvalid got=%b want=100", rv_vec()); end
    checks++; if (bus.rd_d_out !== ref_read(a)) begin failures++; $display("FAIL first_arb_data got=%h want=%h", bus.rd_d_out, ref_read(a)); end
  endtask

  task automatic test_single_read();
    go_idle();
    bus.render_in = 1'b1;
    bus.bg_req_in = 1'b1;
    bus.bg_a_in   = 14'h2001;
    step();
    checks++; if (gnt_vec() !== 3'b100) begin failures++; $display("FAIL single_gnt got=%b want=100", gnt_vec()); end
    checks++; if (bus.vram_a_out !== 14'h2001) begin failures++; $display("FAIL single_addr got=%h want=2001", bus.vram_a_out); end
    checks++; if (bus.vram_we_out !== 1'b0) begin failures++; $display("FAIL single_we got=%b want=0", bus.vram_we_out); end
    clear_reqs();
    step();
    checks++; if ({gnt_vec(), rv_vec()} !== 6'b0) begin failures++; $display("FAIL single_data_cycle got=%b want=000000", {gnt_vec(), rv_vec()}); end
    step();
    checks++; if (rv_vec() !== 3'b100) begin failures++; $display("FAIL single_rvalid got=%b want=100", rv_vec()); end
    checks++; if (bus.rd_d_out !== 8'h5A) begin failures++; $display("FAIL single_rdata got=%h want=5a", bus.rd_d_out); end
    step();
    checks++; if (rv_vec() !== 3'b000) begin failures++; $display("FAIL single_rvalid_width got=%b want=000", rv_vec()); end
    checks++; if (bus.rd_d_out !== 8'h5A) begin failures++; $display("FAIL single_rdata_hold got=%h want=5a", bus.rd_d_out); end
  endtask

  task automatic test_priority(input logic render);
    logic [2:0]        order [3];
    logic [ADDR_W-1:0] a;
    go_idle();
    if (render) begin
      order[0] = 3'b100; order[1] = 3'b010; order[2] = 3'b001;
    end else begin
      order[0] = 3'b001; order[1] = 3'b100; order[2] = 3'b010;
    end
    bus.render_in  = render;
    bus.bg_req_in  = 1'b1; bus.bg_a_in  = 14'h0400;
    bus.spr_req_in = 1'b1; bus.spr_a_in = 14'h0800;
    bus.cpu_req_in = 1'b1; bus.cpu_a_in = 14'h1000; bus.cpu_we_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (gnt_vec() !== order[i]) begin failures++; $display("FAIL prio_gnt render=%0b slot=%0d got=%b want=%b", render, i, gnt_vec(), order[i]); end
      if (order[i] == 3'b100) begin
        a = 14'h0400; bus.bg_req_in = 1'b0;
      end else if (order[i] == 3'b010) begin
        a = 14'h0800; bus.spr_req_in = 1'b0;
      end else begin
        a = 14'h1000; bus.cpu_req_in = 1'b0;
      end
      checks++; if (bus.vram_a_out !== a) begin failures++; $display("FAIL prio_addr slot=%0d got=%h want=%h", i, bus.vram_a_out, a); end
      step();
      checks++; if ({gnt_vec(), rv_vec()} !== 6'b0) begin failures++; $display("FAIL prio_quiet slot=%0d got=%b want=000000", i, {gnt_vec(), rv_vec()}); end
      step();
      checks++; if (rv_vec() !== order[i]) begin failures++; $display("FAIL prio_rvalid slot=%0d got=%b want=%b", i, rv_vec(), order[i]); end
      checks++; if (bus.rd_d_out !== ref_read(a)) begin failures++; $display("FAIL prio_rdata slot=%0d got=%h want=%h", i, bus.rd_d_out, ref_read(a)); end
    end
  endtask

  task automatic test_cpu_write();
    go_idle();
    bus.render_in  = 1'b0;
    bus.cpu_req_in = 1'b1;
    bus.cpu_we_in  = 1'b1;
    bus.cpu_a_in   = 14'h3F00;
    bus.cpu_d_in   = 8'h0F;
    step();
    checks++; if (gnt_vec() !== 3'b001) begin failures++; $display("FAIL wr_gnt got=%b want=001", gnt_vec()); end
    checks++; if (bus.vram_we_out !== 1'b1) begin failures++; $display("FAIL wr_we got=%b want=1", bus.vram_we_out); end
    checks++; if (bus.vram_d_out !== 8'h0F) begin failures++; $display("FAIL wr_wdata got=%h want=0f", bus.vram_d_out); end
    checks++; if (bus.vram_a_out !== 14'h3F00) begin failures++; $display("FAIL wr_addr got=%h want=3f00", bus.vram_a_out); end
    ref_mem[int'(14'h3F00)] = 8'h0F;
    clear_reqs();
    step();
    checks++; if (bus.vram_we_out !== 1'b0) begin failures++; $display("FAIL wr_we_width got=%b want=0", bus.vram_we_out); end
    checks++; if (bus.vram_a_out !== 14'h3F00) begin failures++; $display("FAIL wr_addr_hold got=%h want=3f00", bus.vram_a_out); end
    step();
    checks++; if (rv_vec() !== 3'b000) begin failures++; $display("FAIL wr_no_rvalid got=%b want=000", rv_vec()); end
    // Read the location back.
    bus.cpu_req_in = 1'b1;
    bus.cpu_we_in  = 1'b0;
    step();
    checks++; if (gnt_vec() !== 3'b001) begin failures++; $display("FAIL rdback_gnt got=%b want=001", gnt_vec()); end
    clear_reqs();
    step();
    step();
    checks++; if (rv_vec() !== 3'b001) begin failures++; $display("FAIL rdback_rvalid got=%b want=001", rv_vec()); end
    checks++; if (bus.rd_d_out !== 8'h0F) begin failures++; $display("FAIL rdback_data got=%h want=0f", bus.rd_d_out); end
  endtask

  task automatic test_starvation();
    int bg_cnt;
    bit cpu_seen;
    go_idle();
    bus.render_in  = 1'b1;
    bus.bg_req_in  = 1'b1; bus.bg_a_in  = 14'h0200;
    bus.cpu_req_in = 1'b1; bus.cpu_a_in = 14'h0300; bus.cpu_we_in = 1'b0;
    bg_cnt   = 0;
    cpu_seen = 1'b0;
    for (int c = 0; c < 120 && !cpu_seen; c++) begin
      step();
      if (bus.bg_gnt_out === 1'b1) bg_cnt++;
      if (bus.cpu_gnt_out === 1'b1) cpu_seen = 1'b1;
    end
    clear_reqs();
`ifdef PPU_VRAM_ARB_STARVE_EN
    checks++; if (cpu_seen !== 1'b1) begin failures++; $display("FAIL starve_cpu_grant got=%0b want=1 (timeout)", cpu_seen); end
    checks++; if (bg_cnt !== STARVE_LIMIT) begin failures++; $display("FAIL starve_losses got=%0d want=%0d", bg_cnt, STARVE_LIMIT); end
`else
    checks++; if (cpu_seen !== 1'b0) begin failures++; $display("FAIL starve_cpu_grant got=%0b want=0", cpu_seen); end
    checks++; if (bg_cnt !== 40) begin failures++; $display("FAIL starve_bg_grants got=%0d want=40", bg_cnt); end
`endif
    go_idle();
  endtask

  task automatic test_reset_mid_access();
    go_idle();
    bus.render_in = 1'b1;
    bus.bg_req_in = 1'b1;
    bus.bg_a_in   = 14'h2001;
    step();
    checks++; if (gnt_vec() !== 3'b100) begin failures++; $display("FAIL abort_issue got=%b want=100", gnt_vec()); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({gnt_vec(), rv_vec()} !== 6'b0) begin failures++; $display("FAIL abort_strobes got=%b want=000000", {gnt_vec(), rv_vec()}); end
    checks++; if (bus.vram_we_out !== 1'b0) begin failures++; $display("FAIL abort_we got=%b want=0", bus.vram_we_out); end
    checks++; if (bus.vram_a_out !== '0) begin failures++; $display("FAIL abort_addr got=%h want=0", bus.vram_a_out); end
    checks++; if (bus.rd_d_out !== 8'h00) begin failures++; $display("FAIL abort_rdata got=%h want=00", bus.rd_d_out); end
    clear_reqs();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if ({gnt_vec(), rv_vec()} !== 6'b0) begin failures++; $display("FAIL abort_after cyc=%0d got=%b want=000000", c, {gnt_vec(), rv_vec()}); end
    end
  endtask

  task automatic test_random();
    bit                pend [3];   // index 2=BG, 1=sprite, 0=CPU (matches strobe vectors)
    int                gcyc [3];
    logic [ADDR_W-1:0] ra   [3];
    logic              cwe;
    logic [7:0]        cwd;
    int                free_at;
    int                losses;
    int                w;
    bit   [2:0]        ge;
    bit   [2:0]        ve;
    go_idle();
    bus.render_in = 1'b0;
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b0; gcyc[r] = -1; ra[r] = '0;
    end
    cwe = 1'b0; cwd = 8'h00; free_at = 0; losses = 0;
    for (int k = 0; k < N_RAND; k++) begin
      ge = m_gnt.exists(k) ? m_gnt[k] : 3'b000;
      ve = m_rv.exists(k)  ? m_rv[k]  : 3'b000;
      checks++; if (gnt_vec() !== ge) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b want=%b", k, gnt_vec(), ge); end
      checks++; if (rv_vec() !== ve) begin failures++; $display("FAIL rand_rvalid cyc=%0d got=%b want=%b", k, rv_vec(), ve); end
      if (ve != 3'b000) begin
        checks++; if (bus.rd_d_out !== m_rd[k]) begin failures++; $display("FAIL rand_rdata cyc=%0d got=%h want=%h", k, bus.rd_d_out, m_rd[k]); end
      end
      if (ge != 3'b000) begin
        checks++; if (bus.vram_a_out !== m_a[k]) begin failures++; $display("FAIL rand_addr cyc=%0d got=%h want=%h", k, bus.vram_a_out, m_a[k]); end
        checks++; if (bus.vram_we_out !== m_we[k]) begin failures++; $display("FAIL rand_we cyc=%0d got=%b want=%b", k, bus.vram_we_out, m_we[k]); end
        if (m_we[k]) begin
          checks++; if (bus.vram_d_out !== m_wd[k]) begin failures++; $display("FAIL rand_wdata cyc=%0d got=%h want=%h", k, bus.vram_d_out, m_wd[k]); end
        end
      end else begin
        checks++; if (bus.vram_we_out !== 1'b0) begin failures++; $display("FAIL rand_we_idle cyc=%0d got=%b want=0", k, bus.vram_we_out); end
      end
      m_gnt.delete(k); m_rv.delete(k); m_rd.delete(k);
      m_a.delete(k);   m_we.delete(k); m_wd.delete(k);

      // Requesters: drop on grant, maybe raise a new request.
      for (int r = 0; r < 3; r++) begin
        if (pend[r] && gcyc[r] == k) pend[r] = 1'b0;
        if (!pend[r] && k < N_RAND - 12 && $urandom_range(0, 3) == 0) begin
          pend[r] = 1'b1;
          gcyc[r] = -1;
          ra[r]   = ADDR_W'(32'h0100 + $urandom_range(0, 31));
          if (r == 0) begin
            cwe = 1'($urandom_range(0, 1));
            cwd = 8'($urandom);
          end
        end
      end
      if ($urandom_range(0, 15) == 0) bus.render_in = ~bus.render_in;
      bus.bg_req_in  = pend[2]; bus.bg_a_in  = ra[2];
      bus.spr_req_in = pend[1]; bus.spr_a_in = ra[1];
      bus.cpu_req_in = pend[0]; bus.cpu_a_in = ra[0];
      bus.cpu_we_in  = cwe;     bus.cpu_d_in = cwd;

      // Reference: the arbiter is free to sample every third cycle after an access starts.
      if (k >= free_at) begin
        if (!pend[0]) losses = 0;
        if (pend[0] | pend[1] | pend[2]) begin
          w = -1;
`ifdef PPU_VRAM_ARB_STARVE_EN
          if (pend[0] && losses == STARVE_LIMIT) w = 0;
`endif
          if (w < 0) begin
            if (bus.render_in) w = pend[2] ? 2 : (pend[1] ? 1 : 0);
            else               w = pend[0] ? 0 : (pend[2] ? 2 : 1);
          end
          if (pend[0]) losses = (w == 0) ? 0 : losses + 1;
          m_gnt[k+1] = 3'b001 << w;
          m_a[k+1]   = ra[w];
          m_we[k+1]  = (w == 0) && (cwe == 1'b1);
          m_wd[k+1]  = cwd;
          if (w == 0 && cwe == 1'b1) begin
            ref_mem[int'(ra[0])] = cwd;
          end else begin
            m_rv[k+3] = 3'b001 << w;
            m_rd[k+3] = ref_read(ra[w]);
          end
          gcyc[w] = k + 1;
          free_at = k + 3;
        end
      end
      step();
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority(1'b1);
    test_priority(1'b0);
    test_cpu_write();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arb.md
PPU_VRAM_ARB -- requirements
Module: ppu_vram_arb

Interface
REQ-001 Parameter: ADDR_W, 14, VRAM address width.
REQ-002 Parameter: STARVE_LIMIT, 15, max consecutive lost arbitrations for CPU before forced win (used only with PPU_VRAM_ARB_STARVE_EN).
REQ-003 Ports: clk_in  input  1  system clock; all logic on rising edge.
REQ-004 Ports: rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 Ports: render_in  input  1  1 = rendering active (BG/sprite fetch window).
REQ-006 Ports: bg_req_in  input  1  BG fetch read request; bg_a_in  input  ADDR_W  BG read address.
REQ-007 Ports: spr_req_in  input  1  sprite fetch read request; spr_a_in  input  ADDR_W  sprite read address.
REQ-008 Ports: cpu_req_in  input  1  register-interface request; cpu_we_in  input  1  1 = write; cpu_a_in  input  ADDR_W; cpu_d_in  input  8  write data.
REQ-009 Ports: bg_gnt_out, spr_gnt_out, cpu_gnt_out  output  1 each  one-cycle grant strobes.
REQ-010 Ports: bg_rvalid_out, spr_rvalid_out, cpu_rvalid_out  output  1 each  one-cycle read-data-valid strobes.
REQ-011 Ports: rd_d_out  output  8  read data shared by all requesters, valid with any rvalid strobe.
REQ-012 Ports: vram_a_out  output  ADDR_W; vram_we_out  output  1; vram_d_out  output  8; vram_d_in  input  8  synchronous VRAM, read data valid one cycle after address.

Function
REQ-013 FSM states IDLE, ISSUE, DATA; IDLE->ISSUE when any req sampled high in IDLE; ISSUE->DATA unconditionally; DATA->IDLE unconditionally.
REQ-014 Requests are sampled only in IDLE; req levels in ISSUE/DATA are ignored.
REQ-015 render_in=1: priority BG > sprite > CPU; render_in=0: priority CPU > BG > sprite.
REQ-016 Winner's address, we, wdata latched at IDLE edge; in ISSUE cycle vram_a_out/vram_we_out/vram_d_out driven from latch and winner's gnt high for exactly that cycle.
REQ-017 vram_we_out high only in ISSUE for CPU write; 0 in all other cycles; vram_a_out holds last value outside ISSUE.
REQ-018 Reads: rd_d_out captures vram_d_in at end of DATA; winner's rvalid high in following cycle (IDLE); req-to-rvalid latency 3 cycles, one access per 3 cycles max.
REQ-019 CPU write produces no rvalid; cpu_gnt_out is write completion.
REQ-020 Requester holds req and address stable until gnt and drops req before next IDLE unless issuing a new request; a req still high in IDLE is a new request.
REQ-021 At most one gnt and at most one rvalid high in any cycle; rd_d_out holds value until next read capture.
REQ-022 render_in change while not IDLE does not affect in-flight access; new priority applies at next IDLE sample.

Reset
REQ-023 rst_n_in low asynchronously forces state IDLE, all gnt/rvalid 0, vram_we_out 0, vram_a_out 0, vram_d_out 0, rd_d_out 0, starvation counter 0.
REQ-024 Reset mid-access aborts it: no gnt, rvalid or write strobe for the aborted access after reset release.
REQ-025 First arbitration occurs in the first IDLE cycle after rst_n_in deasserts.

Configuration
REQ-026 Macro PPU_VRAM_ARB_STARVE_EN defined: counter increments on each IDLE arbitration CPU loses while cpu_req_in high, clears on CPU grant or cpu_req_in low; counter == STARVE_LIMIT makes CPU winner regardless of render_in.
REQ-027 Macro undefined: no counter logic; strict priority per REQ-015, CPU may starve indefinitely during rendering.

Verification
REQ-028 Reset: rst_n_in low during ISSUE of BG read -> all strobes 0 immediately, no bg_rvalid_out after release.
REQ-029 Single read: render_in=1, bg_req_in=1, bg_a_in=0x2001, VRAM[0x2001]=0x5A -> bg_gnt_out at cycle+1, vram_a_out=0x2001, bg_rvalid_out with rd_d_out=0x5A at cycle+3.
REQ-030 Priority: all three req high simultaneously, render_in=1 -> grant order BG, sprite, CPU at 3-cycle spacing; render_in=0 -> CPU, BG, sprite.
REQ-031 CPU write: render_in=0, cpu_we_in=1, cpu_a_in=0x3F00, cpu_d_in=0x0F -> vram_we_out=1 one cycle with vram_d_out=0x0F, no cpu_rvalid_out; later read of 0x3F00 returns 0x0F.
REQ-032 Starvation: render_in=1, bg_req_in held high, cpu_req_in high -> with PPU_VRAM_ARB_STARVE_EN CPU granted after 15 lost arbitrations; without macro CPU never granted.
